// File: rtl/pad_bidir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pad_bidir_ctrl
//  Purpose  : Direction sequencer for a bank of bidirectional functional pads.
//             Owns OEN/I/PEN of every pad in the bank, arbitrates a TX write
//             stream against RX sample requests, inserts released turnaround
//             cycles around every drive burst and returns RX data through a
//             synchroniser.
//  Ports    : clk_i       clock (single domain)
//             rst_ni      asynchronous active-low reset
//             tx_valid_i  / tx_ready_o / tx_data_i   TX beat handshake
//             rx_req_i    level request to sample the bank
//             rx_valid_o  / rx_ready_i / rx_data_o   RX result handshake
//             busy_o      sequencer not idle
//             pad_oen_o   pad output enable (1 = drive), all bits identical
//             pad_i_o     pad drive data
//             pad_o_i     pad receive data (asynchronous to clk_i)
//             pad_pen_o   pad pull enable
//  Revision : 1.0  initial release
// ============================================================================
module pad_bidir_ctrl #(
   parameter int Width      = 8,
   parameter int TurnCycles = 2,
   parameter int SyncStages = 2,
   parameter int PullEn     = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   input  logic [Width-1:0] tx_data_i,
   input  logic             rx_req_i,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic [Width-1:0] rx_data_o,
   output logic             busy_o,
   output logic [Width-1:0] pad_oen_o,
   output logic [Width-1:0] pad_i_o,
   input  logic [Width-1:0] pad_o_i,
   output logic [Width-1:0] pad_pen_o
);

   localparam int C_CNT_MAX = (TurnCycles > SyncStages) ? TurnCycles : SyncStages;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
   localparam logic [C_CNT_W-1:0] C_TURN_LOAD = C_CNT_W'(TurnCycles - 1);
   localparam logic [C_CNT_W-1:0] C_SYNC_LOAD = C_CNT_W'(SyncStages - 1);
   localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   generate
      if (Width < 1) begin : g_bad_width
         $error("pad_bidir_ctrl: Width must be >= 1");
      end
      if (TurnCycles < 1) begin : g_bad_turn
         $error("pad_bidir_ctrl: TurnCycles must be >= 1");
      end
      if (SyncStages < 2) begin : g_bad_sync
         $error("pad_bidir_ctrl: SyncStages must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TURN_TX = 3'd1,
      S_DRIVE   = 3'd2,
      S_TURN_RX = 3'd3,
      S_SAMPLE  = 3'd4
   } state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic   [C_CNT_W-1:0]             r_cnt;
   logic   [C_CNT_W-1:0]             w_cnt_nxt;
   logic   [Width-1:0]               r_data;
   logic   [Width-1:0]               w_data_nxt;
   logic                             r_rx_valid;
   logic                             w_rx_valid_nxt;
   logic   [Width-1:0]               r_rx_data;
   logic   [Width-1:0]               w_rx_data_nxt;
   logic                             r_oen;
   logic                             r_pen;
   logic                             r_tx_ready;
   logic   [SyncStages-1:0][Width-1:0] r_sync;
   logic                             w_tx_fire;

   assign w_tx_fire = tx_valid_i & r_tx_ready;

   // ------------------------------------------------------------------------
   // Synchroniser on the pad receive path; runs continuously so that the
   // chain is already settled when a sample window closes.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= pad_o_i;
         for (int i = 1; i < SyncStages; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / datapath decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_data_nxt     = r_data;
      w_rx_valid_nxt = r_rx_valid;
      w_rx_data_nxt  = r_rx_data;
      case (r_state)
         S_IDLE: begin
            // TX has priority; a simultaneous rx_req_i stays pending.
            if (w_tx_fire) begin
               w_data_nxt  = tx_data_i;
               w_cnt_nxt   = C_TURN_LOAD;
               w_state_nxt = S_TURN_TX;
            end else if (rx_req_i) begin
               w_cnt_nxt   = C_SYNC_LOAD;
               w_state_nxt = S_SAMPLE;
            end
         end
         S_TURN_TX: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DRIVE;
            end else begin
               w_cnt_nxt = r_cnt - C_ONE;
            end
         end
         S_DRIVE: begin
            if (w_tx_fire) begin
               w_data_nxt = tx_data_i;
            end else begin
               w_cnt_nxt   = C_TURN_LOAD;
               w_state_nxt = S_TURN_RX;
            end
         end
         S_TURN_RX: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - C_ONE;
            end
         end
         S_SAMPLE: begin
            if (r_rx_valid) begin
               if (rx_ready_i) begin
                  w_rx_valid_nxt = 1'b0;
                  w_state_nxt    = S_IDLE;
               end
            end else begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - C_ONE;
               end
               // The request cycle in IDLE counts as the first of the
               // SyncStages cycles, so capture on the last decrement.
               if (r_cnt == C_ONE) begin
                  w_rx_valid_nxt = 1'b1;
                  w_rx_data_nxt  = r_sync[SyncStages-1];
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers. Pad controls are registered from the
   // next-state decode so the pad pins never see combinational glitches.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_data     <= '0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_oen      <= 1'b0;
         r_pen      <= 1'b0;
         r_tx_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_data     <= w_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_oen      <= (w_state_nxt == S_DRIVE);
         r_pen      <= (w_state_nxt != S_DRIVE) && (PullEn != 0);
         r_tx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DRIVE);
      end
   end

   assign tx_ready_o = r_tx_ready;
   assign rx_valid_o = r_rx_valid;
   assign rx_data_o  = r_rx_data;
   assign busy_o     = (r_state != S_IDLE);
   assign pad_oen_o  = {Width{r_oen}};
   assign pad_pen_o  = {Width{r_pen}};
   assign pad_i_o    = r_data;

   // ------------------------------------------------------------------------
   // Protocol properties
   // ------------------------------------------------------------------------
`ifndef SYNTHESIS
   a_no_drive_after_idle : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (r_state == S_IDLE) |=> !r_oen);

   a_oen_uniform : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (pad_oen_o == {Width{pad_oen_o[0]}}));

   a_rx_data_stable : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (r_rx_valid && !rx_ready_i) |=> $stable(r_rx_data));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_bidir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pad_bidir_ctrl
//  Purpose  : Directed self-checking bench for pad_bidir_ctrl. One instance
//             uses default parameters, a second uses TurnCycles=1,
//             SyncStages=3, PullEn=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pad_bidir_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;

   // default-parameter instance
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data = '0;
   logic       rx_req = 1'b0;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       busy;
   logic [7:0] oen;
   logic [7:0] padi;
   logic [7:0] pado = '0;
   logic [7:0] pen;

   // TurnCycles=1, SyncStages=3, PullEn=0 instance
   logic       tx6_valid = 1'b0;
   logic       tx6_ready;
   logic [7:0] tx6_data = '0;
   logic       rx6_req = 1'b0;
   logic       rx6_valid;
   logic       rx6_ready = 1'b0;
   logic [7:0] rx6_data;
   logic       busy6;
   logic [7:0] oen6;
   logic [7:0] padi6;
   logic [7:0] pado6 = '0;
   logic [7:0] pen6;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   pad_bidir_ctrl dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .tx_data_i  (tx_data),
      .rx_req_i   (rx_req),
      .rx_valid_o (rx_valid),
      .rx_ready_i (rx_ready),
      .rx_data_o  (rx_data),
      .busy_o     (busy),
      .pad_oen_o  (oen),
      .pad_i_o    (padi),
      .pad_o_i    (pado),
      .pad_pen_o  (pen)
   );

   pad_bidir_ctrl #(
      .Width      (8),
      .TurnCycles (1),
      .SyncStages (3),
      .PullEn     (0)
   ) dut6 (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tx_valid_i (tx6_valid),
      .tx_ready_o (tx6_ready),
      .tx_data_i  (tx6_data),
      .rx_req_i   (rx6_req),
      .rx_valid_o (rx6_valid),
      .rx_ready_i (rx6_ready),
      .rx_data_o  (rx6_data),
      .busy_o     (busy6),
      .pad_oen_o  (oen6),
      .pad_i_o    (padi6),
      .pad_o_i    (pado6),
      .pad_pen_o  (pen6)
   );

   // one cycle: step to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_chk++; if ({oen, padi, pen, tx_ready, rx_valid, busy} !== 27'd0) begin
         n_fail++; $display("FAIL reset_outputs got oen=%h padi=%h pen=%h rdy=%b rxv=%b busy=%b exp all 0",
                            oen, padi, pen, tx_ready, rx_valid, busy); end
      n_chk++; if ({oen6, padi6, pen6, tx6_ready, rx6_valid, busy6} !== 27'd0) begin
         n_fail++; $display("FAIL reset_outputs6 got oen=%h pen=%h rdy=%b exp all 0", oen6, pen6, tx6_ready); end
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      n_chk++; if (tx_ready !== 1'b1 || pen !== 8'hFF || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset got rdy=%b pen=%h busy=%b exp 1 ff 0", tx_ready, pen, busy); end
   endtask

   task automatic test_single_beat();
      logic [7:0] exp_oen [1:6];
      exp_oen = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      tx_valid = 1'b1; tx_data = 8'hA5;                 // cycle 0
      tick(); tx_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         n_chk++; if (oen !== exp_oen[c] || pen !== ~exp_oen[c]) begin
            n_fail++; $display("FAIL t1_oen cyc%0d got oen=%h pen=%h exp oen=%h", c, oen, pen, exp_oen[c]); end
         if (c == 3) begin
            n_chk++; if (padi !== 8'hA5) begin
               n_fail++; $display("FAIL t1_padi got %h exp a5", padi); end
         end
         if (c < 6) tick();
      end
      n_chk++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL t1_idle got busy=%b rdy=%b exp 0 1", busy, tx_ready); end
   endtask

   task automatic test_back_to_back();
      tx_valid = 1'b1; tx_data = 8'hA1;                 // cycle 0
      tick(); tx_data = 8'hA2;                          // cycle 1
      n_chk++; if (tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL t2_ready_c1 got %b exp 0", tx_ready); end
      tick();                                           // cycle 2
      n_chk++; if (tx_ready !== 1'b0 || oen !== 8'h00) begin
         n_fail++; $display("FAIL t2_turn_c2 got rdy=%b oen=%h exp 0 00", tx_ready, oen); end
      tick();                                           // cycle 3
      n_chk++; if (oen !== 8'hFF || padi !== 8'hA1 || tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL t2_beat1 got oen=%h padi=%h rdy=%b exp ff a1 1", oen, padi, tx_ready); end
      tick(); tx_data = 8'hA3;                          // cycle 4
      n_chk++; if (oen !== 8'hFF || padi !== 8'hA2) begin
         n_fail++; $display("FAIL t2_beat2 got oen=%h padi=%h exp ff a2", oen, padi); end
      tick(); tx_valid = 1'b0;                          // cycle 5
      n_chk++; if (oen !== 8'hFF || padi !== 8'hA3) begin
         n_fail++; $display("FAIL t2_beat3 got oen=%h padi=%h exp ff a3", oen, padi); end
      for (int c = 6; c <= 7; c++) begin
         tick();
         n_chk++; if (oen !== 8'h00 || busy !== 1'b1 || tx_ready !== 1'b0 || padi !== 8'hA3) begin
            n_fail++; $display("FAIL t2_turn_rx cyc%0d got oen=%h busy=%b rdy=%b padi=%h exp 00 1 0 a3",
                               c, oen, busy, tx_ready, padi); end
      end
      tick();                                           // cycle 8
      n_chk++; if (busy !== 1'b0) begin
         n_fail++; $display("FAIL t2_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_sample();
      pado = 8'h3C;
      tick(); tick(); tick();
      rx_req = 1'b1;                                    // cycle 0
      tick(); rx_req = 1'b0; rx_ready = 1'b1;           // cycle 1, ready ignored
      n_chk++; if (rx_valid !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0 || oen !== 8'h00) begin
         n_fail++; $display("FAIL t3_sample_c1 got rxv=%b busy=%b rdy=%b oen=%h exp 0 1 0 00",
                            rx_valid, busy, tx_ready, oen); end
      tick(); rx_ready = 1'b0; pado = 8'h00;            // cycle 2
      n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
         n_fail++; $display("FAIL t3_valid got rxv=%b data=%h exp 1 3c", rx_valid, rx_data); end
      for (int c = 3; c <= 6; c++) begin
         tick();
         n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C || busy !== 1'b1) begin
            n_fail++; $display("FAIL t3_hold cyc%0d got rxv=%b data=%h busy=%b exp 1 3c 1",
                               c, rx_valid, rx_data, busy); end
      end
      tick(); rx_ready = 1'b1;                          // cycle 7
      tick(); rx_ready = 1'b0;                          // cycle 8
      n_chk++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL t3_release got rxv=%b busy=%b exp 0 0", rx_valid, busy); end
   endtask

   task automatic test_priority();
      bit seen;
      pado = 8'h5A;
      tick(); tick();
      tx_valid = 1'b1; tx_data = 8'hC3; rx_req = 1'b1;  // cycle 0
      tick(); tx_valid = 1'b0;                          // cycle 1
      n_chk++; if (oen !== 8'h00 || rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL t4_turn got oen=%h rxv=%b exp 00 0", oen, rx_valid); end
      tick(); tick();                                   // cycle 3
      n_chk++; if (oen !== 8'hFF || padi !== 8'hC3) begin
         n_fail++; $display("FAIL t4_tx_first got oen=%h padi=%h exp ff c3", oen, padi); end
      tick(); tick();                                   // cycle 5
      n_chk++; if (oen !== 8'h00 || rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL t4_turn_rx got oen=%h rxv=%b exp 00 0", oen, rx_valid); end
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         tick();
         if (busy && !tx_ready) rx_req = 1'b0;          // sampling has started
         if (rx_valid) seen = 1'b1;
      end
      rx_req = 1'b0;
      n_chk++; if (!seen || rx_data !== 8'h5A || oen !== 8'h00) begin
         n_fail++; $display("FAIL t4_rx_after_tx got seen=%b data=%h oen=%h exp 1 5a 00", seen, rx_data, oen); end
      rx_ready = 1'b1;
      tick(); rx_ready = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      tx_valid = 1'b1; tx_data = 8'h77;                 // cycle 0
      tick(); tx_valid = 1'b0;
      tick(); tick();                                   // cycle 3, DRIVE
      n_chk++; if (oen !== 8'hFF || padi !== 8'h77) begin
         n_fail++; $display("FAIL t5_drive got oen=%h padi=%h exp ff 77", oen, padi); end
      tx_valid = 1'b1; tx_data = 8'hEE;                 // pending beat
      #3;
      rst_ni = 1'b0; tx_valid = 1'b0;
      #1;
      n_chk++; if (oen !== 8'h00 || busy !== 1'b0 || padi !== 8'h00 || tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL t5_async got oen=%h busy=%b padi=%h rdy=%b exp 00 0 00 0",
                            oen, busy, padi, tx_ready); end
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_chk++; if (oen !== 8'h00 || busy !== 1'b0 || padi === 8'hEE) begin
            n_fail++; $display("FAIL t5_no_stale cyc%0d got oen=%h busy=%b padi=%h exp 00 0 not-ee",
                               c, oen, busy, padi); end
      end
   endtask

   task automatic test_alt_params();
      logic [7:0] exp_oen [1:4];
      exp_oen = '{8'h00, 8'hFF, 8'h00, 8'h00};
      tx6_valid = 1'b1; tx6_data = 8'h96;               // cycle 0
      tick(); tx6_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_chk++; if (oen6 !== exp_oen[c] || pen6 !== 8'h00) begin
            n_fail++; $display("FAIL t6_oen cyc%0d got oen=%h pen=%h exp oen=%h pen=00", c, oen6, pen6, exp_oen[c]); end
         if (c == 2) begin
            n_chk++; if (padi6 !== 8'h96) begin
               n_fail++; $display("FAIL t6_padi got %h exp 96", padi6); end
         end
         if (c < 4) tick();
      end
      n_chk++; if (busy6 !== 1'b0) begin
         n_fail++; $display("FAIL t6_idle got busy=%b exp 0", busy6); end
      pado6 = 8'hC8;
      tick(); tick(); tick(); tick();
      rx6_req = 1'b1;                                   // cycle 0
      tick(); rx6_req = 1'b0;                           // cycle 1
      tick();                                           // cycle 2
      n_chk++; if (rx6_valid !== 1'b0 || pen6 !== 8'h00) begin
         n_fail++; $display("FAIL t6_rx_early got rxv=%b pen=%h exp 0 00", rx6_valid, pen6); end
      tick();                                           // cycle 3
      n_chk++; if (rx6_valid !== 1'b1 || rx6_data !== 8'hC8) begin
         n_fail++; $display("FAIL t6_rx_valid got rxv=%b data=%h exp 1 c8", rx6_valid, rx6_data); end
      rx6_ready = 1'b1;
      tick(); rx6_ready = 1'b0;
      n_chk++; if (rx6_valid !== 1'b0 || busy6 !== 1'b0) begin
         n_fail++; $display("FAIL t6_rx_done got rxv=%b busy=%b exp 0 0", rx6_valid, busy6); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_sample();
      test_priority();
      test_async_reset();
      test_alt_params();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
